memory_access_unit: RTL

- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Turns a load or store held in M into a req/ack transaction on a variable-latency data bus.
- Stalls the upstream pipeline until the transaction completes.
- Drives the registered MEM/WB outputs: write-back data, destination register and control.

---
 rtl/memory_access_unit_pkg.sv | 20 ++
 rtl/memory_access_unit_mem_wb_reg.sv | 61 ++++++
 rtl/memory_access_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/memory_access_unit_pkg.sv
`default_nettype none
// ==== memory_access_unit_pkg : shared MEM-stage encodings and widths | rev 1.0 ====

package memory_access_unit_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_RF_ADDR_WIDTH = 5;

  // One extra bit so TIMEOUT_CYCLES-1 always fits, including TIMEOUT_CYCLES=1.
  function automatic int timeout_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_access_unit_mem_wb_reg.sv
`default_nettype none
// ==== mem_wb_reg : MEM/WB pipeline register with bubble insertion | rev 1.0 ====

module mem_wb_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_bubble,
  input  logic [DATA_WIDTH-1:0]    i_alu_out,
  input  logic [DATA_WIDTH-1:0]    i_read_data,
  input  logic [RF_ADDR_WIDTH-1:0] i_write_reg,
  input  logic                     i_reg_write,
  input  logic                     i_mem_to_reg,
  output logic [DATA_WIDTH-1:0]    o_alu_out,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic [RF_ADDR_WIDTH-1:0] o_write_reg,
  output logic                     o_reg_write,
  output logic                     o_mem_to_reg
);

  logic [DATA_WIDTH-1:0]    alu_out_d, alu_out_q;
  logic [DATA_WIDTH-1:0]    read_data_d, read_data_q;
  logic [RF_ADDR_WIDTH-1:0] write_reg_d, write_reg_q;
  logic                     reg_write_d, reg_write_q;
  logic                     mem_to_reg_d, mem_to_reg_q;

  always_comb begin
    alu_out_d    = i_bubble ? '0   : i_alu_out;
    read_data_d  = i_bubble ? '0   : i_read_data;
    write_reg_d  = i_bubble ? '0   : i_write_reg;
    reg_write_d  = i_bubble ? 1'b0 : i_reg_write;
    mem_to_reg_d = i_bubble ? 1'b0 : i_mem_to_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      alu_out_q    <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign o_alu_out    = alu_out_q;
  assign o_read_data  = read_data_q;
  assign o_write_reg  = write_reg_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_to_reg = mem_to_reg_q;

endmodule

`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ==== memory_access_unit : M-stage load/store bus FSM with stall and timeout | rev 1.0 ====

module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int RF_ADDR_WIDTH  = DEF_RF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic                     i_RegWriteM,
  input  logic                     i_MemtoRegM,
  input  logic                     i_MemWriteM,
  output logic                     o_StallM,
  output logic                     o_BusReq,
  output logic                     o_BusWe,
  output logic [ADDRESS_WIDTH-1:0] o_BusAddr,
  output logic [DATA_WIDTH-1:0]    o_BusWData,
  input  logic                     i_BusAck,
  input  logic [DATA_WIDTH-1:0]    i_BusRData,
  output logic [DATA_WIDTH-1:0]    o_ALUOutW,
  output logic [DATA_WIDTH-1:0]    o_ReadDataW,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic                     o_RegWriteW,
  output logic                     o_MemtoRegW,
  output logic                     o_MemErr
);

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             mem_err_d, mem_err_q;

  logic w_memop, w_is_load, w_in_access, w_final_cycle, w_bubble;

  always_comb begin
    w_memop       = i_MemtoRegM | i_MemWriteM;
    w_is_load     = i_MemtoRegM & ~i_MemWriteM;
    w_in_access   = (state_q == ST_ACCESS);
    w_final_cycle = (cnt_q == CNT_LAST);

    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = 1'b0;
    w_bubble  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (w_memop) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end else begin
          w_bubble = 1'b0;
        end
      end
      ST_ACCESS: begin
        // Ack on the last allowed cycle completes normally rather than aborting.
        if (i_BusAck) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          w_bubble = 1'b0;
        end else if (w_final_cycle) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Stall depends only on state/counter/memop/ack, never on anything it drives.
  assign o_StallM = ~i_RST & ((~w_in_access & w_memop) |
                              (w_in_access & ~i_BusAck & ~w_final_cycle));

  assign o_BusReq   = w_in_access;
  assign o_BusWe    = w_in_access & i_MemWriteM;
  assign o_BusAddr  = w_in_access ? i_ALUOutM[ADDRESS_WIDTH-1:0] : '0;
  assign o_BusWData = w_in_access ? i_WriteDataM : '0;
  assign o_MemErr   = mem_err_q;

  mem_wb_reg #(
    .DATA_WIDTH    (DATA_WIDTH),
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
  ) u_mem_wb_reg (
    .i_clk        (i_CLK),
    .i_rst        (i_RST),
    .i_bubble     (w_bubble),
    .i_alu_out    (i_ALUOutM),
    .i_read_data  (w_is_load ? i_BusRData : '0),
    .i_write_reg  (i_WriteRegM),
    .i_reg_write  (i_RegWriteM),
    .i_mem_to_reg (w_is_load),
    .o_alu_out    (o_ALUOutW),
    .o_read_data  (o_ReadDataW),
    .o_write_reg  (o_WriteRegW),
    .o_reg_write  (o_RegWriteW),
    .o_mem_to_reg (o_MemtoRegW)
  );

endmodule

`default_nettype wire
